// File: rtl/two_bit_mc_dataflow.sv
// rtl/two_bit_mc_dataflow.sv - registered unsigned magnitude comparator from cascaded 2-bit slices
//
// Purpose: compares unsigned operands a and b and reports exactly one of
//          greater / equal / less, registered one cycle after a valid sample.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   sample a/b on this edge when high
//   a, b       unsigned operands, WIDTH bits
//   a_gt_b     registered A > B
//   a_eq_b     registered A == B
//   a_lt_b     registered A < B
//   out_valid  registered, high when the flags hold a fresh result

module two_bit_mc_dataflow #(
    parameter int WIDTH   = 4,
    parameter int SLICE_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             out_valid
);

    // Odd widths are padded with a zero MSB so every slice is full.
    localparam int WE = WIDTH + (WIDTH % 2);
    localparam int NS = WE / SLICE_W;

    logic [WE-1:0] a_ext;
    logic [WE-1:0] b_ext;

    assign a_ext = WE'(a);
    assign b_ext = WE'(b);

    logic [NS-1:0] slice_gt;
    logic [NS-1:0] slice_eq;
    logic [NS-1:0] slice_lt;

    // Pure dataflow slice equations; no relational operators.
    for (genvar s = 0; s < NS; s++) begin : g_slice
        logic a1, a0, b1, b0;
        assign a1 = a_ext[2*s+1];
        assign a0 = a_ext[2*s];
        assign b1 = b_ext[2*s+1];
        assign b0 = b_ext[2*s];

        assign slice_gt[s] = (a1 & ~b1) | ((a1 ~^ b1) & a0 & ~b0);
        assign slice_eq[s] = (a1 ~^ b1) & (a0 ~^ b0);
        assign slice_lt[s] = (~a1 & b1) | ((a1 ~^ b1) & ~a0 & b0);
    end

    logic gt_d, eq_d, lt_d;
    logic decided;

    // Walk from the MSB slice down; the first unequal slice owns the verdict.
    always_comb begin
        gt_d    = 1'b0;
        lt_d    = 1'b0;
        decided = 1'b0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (!decided && !slice_eq[i]) begin
                gt_d    = slice_gt[i];
                lt_d    = slice_lt[i];
                decided = 1'b1;
            end
        end
        eq_d = &slice_eq;
    end

    logic gt_q, eq_q, lt_q, valid_q;

    // Flags load only on a valid sample so they hold across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                gt_q <= gt_d;
                eq_q <= eq_d;
                lt_q <= lt_d;
            end
        end
    end

    assign a_gt_b    = gt_q;
    assign a_eq_b    = eq_q;
    assign a_lt_b    = lt_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_two_bit_mc_dataflow.sv
// tb/tb_two_bit_mc_dataflow.sv - self-checking bench for two_bit_mc_dataflow

module tb_two_bit_mc_dataflow;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       g4, e4, l4, v4;
    logic       g8, e8, l8, v8;

    two_bit_mc_dataflow #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a4),
        .b         (b4),
        .a_gt_b    (g4),
        .a_eq_b    (e4),
        .a_lt_b    (l4),
        .out_valid (v4)
    );

    two_bit_mc_dataflow #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a8),
        .b         (b8),
        .a_gt_b    (g8),
        .a_eq_b    (e8),
        .a_lt_b    (l8),
        .out_valid (v8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: {gt, eq, lt} flags and expected out_valid.
    logic [2:0] ef4, ef8;
    logic       ev;

    function automatic logic [2:0] ref_cmp(input int unsigned x, input int unsigned y);
        return {x > y, x == y, x < y};
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_w4"}, {v4, g4, e4, l4}, {ev, ef4});
        chk({tag, "_w8"}, {v8, g8, e8, l8}, {ev, ef8});
        if (v4) chk({tag, "_onehot4"}, 4'($countones({g4, e4, l4})), 4'd1);
        if (v8) chk({tag, "_onehot8"}, 4'($countones({g8, e8, l8})), 4'd1);
    endtask

    // One sampled edge: drive at negedge, check just after the posedge.
    task automatic step(input logic [3:0] x, input logic [3:0] y, input logic v, input string tag);
        @(negedge clk);
        a4       = x;
        b4       = y;
        a8       = 8'($urandom);
        b8       = ($urandom_range(0, 3) == 0) ? a8 : 8'($urandom);
        in_valid = v;
        @(posedge clk);
        #1;
        if (v) begin
            ef4 = ref_cmp(x, y);
            ef8 = ref_cmp(a8, b8);
        end
        ev = v;
        check_all(tag);
    endtask

    // Asynchronous reset pulse landing between two sampled edges.
    task automatic reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        ef4 = 3'b000;
        ef8 = 3'b000;
        ev  = 1'b0;
        check_all({tag, "_async_clear"});
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check_all({tag, "_no_stale"});
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a4       = 4'd5;
        b4       = 4'd3;
        a8       = 8'd200;
        b8       = 8'd100;
        ef4      = 3'b000;
        ef8      = 3'b000;
        ev       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold");

        @(negedge clk);
        rst_n = 1'b1;

        step(4'd5,  4'd3,  1'b1, "sweep_5_3");
        step(4'd7,  4'd7,  1'b1, "sweep_7_7");
        step(4'd2,  4'd9,  1'b1, "sweep_2_9");
        step(4'd15, 4'd0,  1'b1, "sweep_15_0");
        step(4'd1,  4'd15, 1'b1, "sweep_1_15");

        step(4'd4,  4'd3,  1'b1, "upper_4_3");
        step(4'd3,  4'd4,  1'b1, "upper_3_4");
        step(4'd6,  4'd5,  1'b1, "lower_6_5");

        step(4'd5,  4'd3,  1'b1, "gate_on_5_3");
        step(4'd2,  4'd9,  1'b0, "gate_off_2_9");
        step(4'd2,  4'd9,  1'b0, "gate_off_hold");

        step(4'd7,  4'd7,  1'b1, "mid_cycle_pre");
        reset_pulse("mid_cycle");

        step(4'd5,  4'd3,  1'b1, "inflight_5_3");
        reset_pulse("inflight");
        step(4'd2,  4'd9,  1'b1, "post_reset_2_9");

        for (int i = 0; i < 256; i++) begin
            step(4'(i >> 4), 4'(i), 1'b1, "exhaustive");
        end

        for (int i = 0; i < 120; i++) begin
            step(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/two_bit_mc_dataflow.md
Name: two_bit_mc_dataflow

Overview:
- Registered unsigned magnitude comparator built from cascaded 2-bit dataflow comparator slices.
- Compares operands a and b and reports exactly one of greater, equal or less, one clock after the sample is taken.
- Used as a leaf compare block in datapath control (thresholds, sorting, range checks).
- Default operand width is 4 bits (two 2-bit slices).

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32. Odd values are zero-extended internally to the next even width.
- SLICE_W, 2, slice width; fixed at 2, not overridable in practice.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  when high, a/b are sampled on this clk edge.
- a  input  WIDTH  unsigned operand A.
- b  input  WIDTH  unsigned operand B.
- a_gt_b  output  1  registered; 1 when A > B.
- a_eq_b  output  1  registered; 1 when A == B.
- a_lt_b  output  1  registered; 1 when A < B.
- out_valid  output  1  registered; 1 when the flags hold a fresh result.

Behaviour:
- Reset:
  - rst_n low immediately (asynchronously) forces a_gt_b=0, a_eq_b=0, a_lt_b=0, out_valid=0.
  - Deassertion takes effect at the next clk edge.
- Slice function: operands are split into WIDTH/2 two-bit slices, MSB slice first. Each slice produces slice_gt, slice_eq and slice_lt as pure dataflow equations, no behavioural compare operator:
  - gt = a1&~b1 | (a1~^b1)&a0&~b0
  - eq = (a1~^b1)&(a0~^b0)
  - lt = ~a1&b1 | (a1~^b1)&~a0&b0
- Cascade, from MSB slice down:
  - The first slice with eq=0 decides gt/lt.
  - eq is the AND of all slice eq terms.
  - The combinational result is then registered.
- Latency: 1 cycle. A result for inputs sampled at edge N with in_valid=1 appears after edge N, alongside out_valid=1.
- in_valid=0 at an edge:
  - out_valid goes 0.
  - The flag outputs hold their previous values; no new compare is loaded.
- Invariant: whenever out_valid=1, exactly one of a_gt_b, a_eq_b, a_lt_b is 1 (one-hot).
- Arithmetic: unsigned only. The all-ones vs zero extremes must compare correctly (15 > 0, 1 < 15 at WIDTH=4).
- Back-to-back: a new sample is accepted every cycle. There is no stall or backpressure.
- Reset mid-stream: an in-flight result is discarded and outputs return to reset values. The first valid result after reset needs one more sampled edge.
- Inputs are not registered before comparison. Setup is relative to the sampling edge only.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=5, b=3 -> all flags 0 and out_valid=0; assert rst_n low mid-cycle -> outputs clear without waiting for a clk edge.
- Directed sweep, WIDTH=4, one per cycle with in_valid=1 -> each result appears one cycle later with out_valid=1:
  - (5,3) -> gt=1
  - (7,7) -> eq=1
  - (2,9) -> lt=1
  - (15,0) -> gt=1
  - (1,15) -> lt=1
- Slice boundary: (4,3) and (3,4) -> gt and lt respectively, decided by the upper slice; (6,5) -> gt, decided by the lower slice with the upper slice equal.
- Valid gating: (5,3) with in_valid=1, then (2,9) with in_valid=0 -> flags stay gt=1 and out_valid drops to 0 on the second cycle.
- Exhaustive: all 256 pairs at WIDTH=4 plus random pairs at WIDTH=8 -> flags match a reference unsigned compare and one-hot holds every valid cycle.
- Reset mid-operation: rst_n pulsed low between two valid samples -> no stale result appears; the next valid result arrives one cycle after the first post-reset sampled edge.
